// File: rtl/spi_burst_master.sv
// SPI mode-3 burst master: one command byte {read, addr} followed by 1..MAX_BYTES data bytes.
// SPC idles high, and every bit is a low phase then a high phase of DIV clk cycles each.
// All pin outputs (SPC, CS, SDI, busy, done) are registered. They therefore follow the
// internal FSM state by one clk cycle.
//
// Ports:
//   i_clk     system clock; all logic runs on its rising edge
//   i_reset   synchronous active-high reset
//   i_start   transfer request; sampled only while idle
//   i_read    1 = read burst, 0 = write burst (command bit 7)
//   i_addr    register address (command bits 6:0)
//   i_len     data byte count; 0 is treated as 1, and values above MAX_BYTES as MAX_BYTES
//   i_wdata   write payload; byte k in [8k+7:8k], byte 0 sent first
//   i_sdo     serial data from the device
//   o_spc     serial clock, idle high
//   o_cs      chip select, active low
//   o_sdi     serial data to the device
//   o_rdata   read payload; k-th received byte in [8k+7:8k]
//   o_busy    high while a transfer is in progress
//   o_done    one-cycle completion pulse
module spi_burst_master #(
    parameter int unsigned MAX_BYTES = 12,
    parameter int unsigned DIV       = 1,
    parameter int unsigned LEN_W     = $clog2(MAX_BYTES + 1)
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_start,
    input  logic                   i_read,
    input  logic [6:0]             i_addr,
    input  logic [LEN_W-1:0]       i_len,
    input  logic [8*MAX_BYTES-1:0] i_wdata,
    input  logic                   i_sdo,
    output logic                   o_spc,
    output logic                   o_cs,
    output logic                   o_sdi,
    output logic [8*MAX_BYTES-1:0] o_rdata,
    output logic                   o_busy,
    output logic                   o_done
);

    localparam int unsigned DIV_W = $clog2(DIV + 1);
    localparam int unsigned CNT_W = LEN_W + 1;
    localparam int unsigned IDX_W = $clog2(8 * MAX_BYTES);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [LEN_W-1:0] MAX_LEN  = LEN_W'(MAX_BYTES);

    typedef enum logic [1:0] {StIdle, StShift, StHold, StFin} state_t;

    state_t                 r_state, w_state_nxt;
    logic                   r_phase, w_phase_nxt;  // 0 = SPC low half, 1 = SPC high half
    logic [DIV_W-1:0]       r_div, w_div_nxt;
    logic [2:0]             r_bit, w_bit_nxt;
    logic [CNT_W-1:0]       r_byte, w_byte_nxt;    // 0 = command byte
    logic [LEN_W-1:0]       r_nbytes;
    logic                   r_read;
    logic [6:0]             r_addr;
    logic [8*MAX_BYTES-1:0] r_wdata;               // current data byte always in [7:0]
    logic [8*MAX_BYTES-1:0] r_rdata;
    logic                   r_spc, r_cs, r_sdi, r_busy, r_done;

    logic                   w_accept;
    logic                   w_shift_wdata;
    logic                   w_div_last;
    logic [LEN_W-1:0]       w_nbytes;
    logic [7:0]             w_tx_byte;
    logic                   w_tx_bit;
    logic [CNT_W-1:0]       w_byte_m1;
    logic [IDX_W-1:0]       w_rx_idx;
    logic                   w_rx_take;

    assign w_div_last = (r_div == DIV_LAST);

    assign w_nbytes = (i_len == '0)     ? LEN_W'(1) :
                      (i_len > MAX_LEN) ? MAX_LEN   : i_len;

    // Read bursts drive zeros during the data phase.
    assign w_tx_byte = (r_byte == '0) ? {r_read, r_addr} :
                       (r_read ? 8'h00 : r_wdata[7:0]);
    assign w_tx_bit  = w_tx_byte[~r_bit];

    // Bit j of data byte k lands at 8k+7-j, i.e. {k, ~j}.
    assign w_byte_m1 = r_byte - CNT_W'(1);
    assign w_rx_idx  = IDX_W'({w_byte_m1, ~r_bit});

    // First cycle of a high phase: this is the edge on which the SPC register rises.
    assign w_rx_take = (r_state == StShift) && r_phase && (r_div == '0) && r_read &&
                       (r_byte != '0);

    always_comb begin
        w_state_nxt   = r_state;
        w_phase_nxt   = r_phase;
        w_div_nxt     = r_div;
        w_bit_nxt     = r_bit;
        w_byte_nxt    = r_byte;
        w_shift_wdata = 1'b0;
        w_accept      = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (i_start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = StShift;
                    w_phase_nxt = 1'b0;
                    w_div_nxt   = '0;
                    w_bit_nxt   = '0;
                    w_byte_nxt  = '0;
                end
            end
            StShift: begin
                if (w_div_last) begin
                    w_div_nxt = '0;
                    if (!r_phase) begin
                        w_phase_nxt = 1'b1;
                    end else begin
                        w_phase_nxt = 1'b0;
                        w_bit_nxt   = r_bit + 3'd1;
                        if (r_bit == 3'd7) begin
                            if (r_byte != '0) begin
                                w_shift_wdata = 1'b1;
                            end
                            if (r_byte == {1'b0, r_nbytes}) begin
                                w_state_nxt = StHold;
                            end else begin
                                w_byte_nxt = r_byte + CNT_W'(1);
                            end
                        end
                    end
                end else begin
                    w_div_nxt = r_div + DIV_W'(1);
                end
            end
            StHold: begin
                if (w_div_last) begin
                    w_div_nxt   = '0;
                    w_state_nxt = StFin;
                end else begin
                    w_div_nxt = r_div + DIV_W'(1);
                end
            end
            StFin: begin
                w_state_nxt = StIdle;
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state  <= StIdle;
            r_phase  <= 1'b0;
            r_div    <= '0;
            r_bit    <= '0;
            r_byte   <= '0;
            r_nbytes <= '0;
            r_read   <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
            r_spc    <= 1'b1;
            r_cs     <= 1'b1;
            r_sdi    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_phase <= w_phase_nxt;
            r_div   <= w_div_nxt;
            r_bit   <= w_bit_nxt;
            r_byte  <= w_byte_nxt;
            if (w_accept) begin
                r_read   <= i_read;
                r_addr   <= i_addr;
                r_wdata  <= i_wdata;
                r_nbytes <= w_nbytes;
                r_rdata  <= '0;
            end else begin
                if (w_shift_wdata) begin
                    r_wdata <= r_wdata >> 8;
                end
                if (w_rx_take) begin
                    r_rdata[w_rx_idx] <= i_sdo;
                end
            end
            r_spc  <= !((r_state == StShift) && !r_phase);
            r_cs   <= !((r_state == StShift) || (r_state == StHold));
            if (r_state == StShift) begin
                r_sdi <= w_tx_bit;
            end
            r_busy <= (r_state != StIdle);
            r_done <= (r_state == StFin);
        end
    end

    assign o_spc   = r_spc;
    assign o_cs    = r_cs;
    assign o_sdi   = r_sdi;
    assign o_rdata = r_rdata;
    assign o_busy  = r_busy;
    assign o_done  = r_done;

endmodule

// File: tb/tb_spi_burst_master.sv
// Bench for spi_burst_master. Two instances run side by side, one with DIV=1 and one with DIV=2,
// and both are driven by the same request inputs. Each instance has its own slave model.
module tb_spi_burst_master;

    localparam int unsigned MB = 12;
    localparam int unsigned LW = $clog2(MB + 1);
    localparam int unsigned W  = 8 * MB;

    logic          clk = 1'b0;
    logic          reset, start, rd;
    logic [6:0]    addr;
    logic [LW-1:0] len;
    logic [W-1:0]  wdata;
    logic [1:0]    sdo = 2'b00;
    logic [1:0]    spc, cs, sdi, busy, done;
    logic [W-1:0]  rdata0, rdata1;

    always #5 clk = ~clk;

    spi_burst_master #(.MAX_BYTES(MB), .DIV(1)) u_dut_d1 (
        .i_clk(clk), .i_reset(reset), .i_start(start), .i_read(rd), .i_addr(addr), .i_len(len),
        .i_wdata(wdata), .i_sdo(sdo[0]), .o_spc(spc[0]), .o_cs(cs[0]), .o_sdi(sdi[0]),
        .o_rdata(rdata0), .o_busy(busy[0]), .o_done(done[0])
    );

    spi_burst_master #(.MAX_BYTES(MB), .DIV(2)) u_dut_d2 (
        .i_clk(clk), .i_reset(reset), .i_start(start), .i_read(rd), .i_addr(addr), .i_len(len),
        .i_wdata(wdata), .i_sdo(sdo[1]), .o_spc(spc[1]), .o_cs(cs[1]), .o_sdi(sdi[1]),
        .o_rdata(rdata1), .o_busy(busy[1]), .o_done(done[1])
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Slave behaviour and pin monitors, all sampled on the falling clk edge.
    logic [7:0]   resp [MB];
    int           rise_cnt [2];
    int           cs_low [2];
    int           done_tot [2];
    int           done_cyc [2];
    int           gap [2];
    int           fall_idx [2];
    logic [127:0] sdi_bits [2];
    logic [1:0]   prev_spc = 2'b11;
    logic [1:0]   prev_cs = 2'b11;

    initial begin
        for (int g = 0; g < 2; g++) begin
            rise_cnt[g] = 0; cs_low[g] = 0; done_tot[g] = 0; done_cyc[g] = -1000;
            gap[g] = 0; fall_idx[g] = 0; sdi_bits[g] = '0;
        end
    end

    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (!cs[g] && prev_cs[g]) begin
                fall_idx[g] = 0; rise_cnt[g] = 0; cs_low[g] = 0; sdi_bits[g] = '0;
                gap[g] = cyc - done_cyc[g];
            end
            if (!cs[g]) cs_low[g]++;
            if (!cs[g] && spc[g] && !prev_spc[g]) begin
                if (rise_cnt[g] < 128) sdi_bits[g][rise_cnt[g]] = sdi[g];
                rise_cnt[g]++;
            end
            if (!cs[g] && !spc[g] && prev_spc[g]) begin
                if (fall_idx[g] < 8) begin
                    // Junk during the command byte; the master must discard it.
                    sdo[g] <= 1'($urandom);
                end else begin
                    sdo[g] <= ((fall_idx[g] - 8) / 8 < MB) ?
                              resp[(fall_idx[g] - 8) / 8][7 - ((fall_idx[g] - 8) % 8)] : 1'b0;
                end
                fall_idx[g]++;
            end
            if (done[g]) begin
                done_tot[g]++;
                done_cyc[g] = cyc;
            end
            prev_spc[g] = spc[g];
            prev_cs[g]  = cs[g];
        end
    end

    int total = 0;
    int bad = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] rdata_of(input int g);
        return (g == 0) ? rdata0 : rdata1;
    endfunction

    // Reference model: frame contents and timing derived directly from the transfer rules.
    int           exp_n;
    logic [127:0] exp_bits;
    logic [W-1:0] exp_rdata;

    task automatic model(input logic r, input logic [6:0] a, input logic [LW-1:0] l,
                         input logic [W-1:0] wd);
        logic [7:0] b;
        exp_n     = (l == 0) ? 1 : ((int'(l) > MB) ? MB : int'(l));
        exp_bits  = '0;
        exp_rdata = '0;
        for (int i = 0; i < 8 * (exp_n + 1); i++) begin
            if (i / 8 == 0) b = {r, a};
            else            b = r ? 8'h00 : wd[8 * (i / 8 - 1) +: 8];
            exp_bits[i] = b[7 - i % 8];
        end
        if (r) begin
            for (int k = 0; k < exp_n; k++) exp_rdata[8 * k +: 8] = resp[k];
        end
    endtask

    task automatic run_txn(input logic r, input logic [6:0] a, input logic [LW-1:0] l,
                           input logic [W-1:0] wd, input bit fixed_resp, input int pulse_at);
        int d [2];
        int t0;
        int waited;
        for (int k = 0; k < MB; k++) resp[k] = fixed_resp ? 8'(k + 1) : 8'($urandom);
        model(r, a, l, wd);
        d[0] = done_tot[0];
        d[1] = done_tot[1];
        @(negedge clk);
        rd = r; addr = a; len = l; wdata = wd; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t0 = cyc;
        // Latched values must be immune to later input changes.
        rd = 1'($urandom); addr = 7'($urandom); len = LW'($urandom);
        wdata = {$urandom, $urandom, $urandom};
        waited = 0;
        while ((done_tot[0] == d[0] || done_tot[1] == d[1]) && waited < 2000) begin
            start = (waited == pulse_at);
            @(negedge clk);
            waited++;
        end
        start = 1'b0;
        repeat (3) @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            check("done_count", 128'(done_tot[g] - d[g]), 128'(1));
            check("latency", 128'(done_cyc[g] - t0),
                  128'(1 + 2 * (g + 1) * 8 * (exp_n + 1) + (g + 1)));
            check("spc_rises", 128'(rise_cnt[g]), 128'(8 * (exp_n + 1)));
            check("cs_low_cycles", 128'(cs_low[g]), 128'(2 * (g + 1) * 8 * (exp_n + 1) + (g + 1)));
            check("sdi_bits", sdi_bits[g], exp_bits);
            check("rdata", 128'(rdata_of(g)), 128'(exp_rdata));
            check("idle_after", 128'({cs[g], spc[g], busy[g], done[g]}), 128'(4'b1100));
        end
    endtask

    initial begin
        int base [2];
        int waited;
        logic [W-1:0] wd_c;
        reset = 1'b1; start = 1'b0; rd = 1'b0; addr = '0; len = '0; wdata = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Idle after reset.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            for (int g = 0; g < 2; g++) begin
                check("idle_pins", 128'({spc[g], cs[g], sdi[g], busy[g], done[g]}), 128'(5'b11000));
                check("idle_rdata", 128'(rdata_of(g)), 128'(0));
            end
        end

        // Directed write and read.
        run_txn(1'b0, 7'h20, LW'(1), W'(8'hA5), 1'b0, -1);
        check("wr_bits_const", sdi_bits[0], 128'(16'b1010010100000100));
        run_txn(1'b1, 7'h28, LW'(6), {$urandom, $urandom, $urandom}, 1'b1, -1);
        check("rd6_const", 128'(rdata1), 128'(48'h060504030201));

        // Length clamping at both ends.
        run_txn(1'b0, 7'h55, LW'(0), {$urandom, $urandom, $urandom}, 1'b0, -1);
        run_txn(1'b0, 7'h3C, LW'(15), {$urandom, $urandom, $urandom}, 1'b0, -1);
        run_txn(1'b1, 7'h7F, LW'(15), {$urandom, $urandom, $urandom}, 1'b0, -1);
        run_txn(1'b1, 7'h01, LW'(12), {$urandom, $urandom, $urandom}, 1'b0, -1);

        // Random bursts.
        for (int i = 0; i < 6; i++) begin
            run_txn(1'($urandom), 7'($urandom), LW'($urandom_range(15)),
                    {$urandom, $urandom, $urandom}, 1'b0, -1);
        end

        // start pulse while busy is ignored.
        run_txn(1'b1, 7'($urandom), LW'(3), {$urandom, $urandom, $urandom}, 1'b0, 10);

        // start held high: back-to-back frames, FIN plus one idle cycle between them.
        wd_c = {$urandom, $urandom, $urandom};
        model(1'b0, 7'h11, LW'(2), wd_c);
        base[0] = done_tot[0];
        base[1] = done_tot[1];
        @(negedge clk);
        rd = 1'b0; addr = 7'h11; len = LW'(2); wdata = wd_c; start = 1'b1;
        waited = 0;
        while ((done_tot[0] < base[0] + 3 || done_tot[1] < base[1] + 2) && waited < 3000) begin
            @(negedge clk);
            waited++;
        end
        start = 1'b0;
        repeat (200) @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            check("b2b_progress", 128'(done_tot[g] >= base[g] + 2), 128'(1));
            check("b2b_gap", 128'(gap[g]), 128'(2));
            check("b2b_bits", sdi_bits[g], exp_bits);
            check("b2b_idle", 128'({cs[g], busy[g]}), 128'(2'b10));
        end

        // Reset in the middle of a read.
        for (int k = 0; k < MB; k++) resp[k] = 8'hFF;
        base[0] = done_tot[0];
        base[1] = done_tot[1];
        @(negedge clk);
        rd = 1'b1; addr = 7'h28; len = LW'(4); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        check("pre_reset_rdata_nz", 128'(rdata0 != '0), 128'(1));
        reset = 1'b1;
        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            check("reset_pins", 128'({cs[g], spc[g], busy[g], done[g]}), 128'(4'b1100));
            check("reset_rdata", 128'(rdata_of(g)), 128'(0));
        end
        reset = 1'b0;
        repeat (250) @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            check("reset_no_done", 128'(done_tot[g] - base[g]), 128'(0));
        end
        run_txn(1'b1, 7'h28, LW'(4), {$urandom, $urandom, $urandom}, 1'b0, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_burst_master.md
Name: spi_burst_master

Overview:
- Parametrised SPI mode-3 master. Runtime-selectable read or write bursts of 1..MAX_BYTES data bytes after a single command byte.
- Programmable SPC rate via a half-period divider, plus a start/busy/done handshake.
- Sits between sensor/config controllers and the off-chip SPI device (SPC/CS/SDI/SDO pins). It serves single-register accesses and multi-byte sample reads with one engine.

Parameters:
- MAX_BYTES, 12, maximum data bytes per transaction (1..16).
- DIV, 1, SPC half-period in clk cycles (>=1).
- LEN_W, $clog2(MAX_BYTES+1), width of the len input.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only while idle.
- read  input  1  1 = read burst, 0 = write burst; becomes command bit 7.
- addr  input  7  register address; becomes command bits 6:0.
- len  input  LEN_W  number of data bytes.
- wdata  input  8*MAX_BYTES  write payload; byte k in bits [8k+7:8k], byte 0 sent first.
- SDO  input  1  serial data from the device.
- SPC  output  1  serial clock, idle high.
- CS  output  1  chip select, active low.
- SDI  output  1  serial data to the device.
- rdata  output  8*MAX_BYTES  read payload; byte k (k-th received) in bits [8k+7:8k].
- busy  output  1  high whenever not idle.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset values: SPC=1, CS=1, SDI=0, rdata=0, busy=0, done=0, FSM=IDLE. Reset mid-transfer aborts on the next edge with these values and no done pulse.
- States: IDLE -> SHIFT -> HOLD -> FIN -> IDLE.
- IDLE, start=1:
  - Latch read, addr, wdata.
  - Latch nbytes = len clamped: len=0 gives 1; len>MAX_BYTES gives MAX_BYTES.
  - Clear rdata to 0. Go to SHIFT.
  - start in any other state is ignored; no queuing.
- SHIFT:
  - CS=0. Frame = {read, addr[6:0]} then nbytes data bytes, MSB first. Total bits = 8*(nbytes+1).
  - Each bit is a low phase of DIV cycles (SPC=0) followed by a high phase of DIV cycles (SPC=1).
  - SDI takes the new bit on the first cycle of the low phase and holds it through the high phase.
  - Data bits: write mode sends wdata bytes; read mode sends SDI=0.
  - SDO is captured on the clk edge where SPC goes 0->1, for data bits only, and only when read=1. Received bit j of byte k goes to rdata[8k+7-j].
  - The command-byte SDO is discarded. Write mode leaves rdata at 0.
- After the last high phase, go to HOLD: CS=0, SPC=1, for DIV cycles.
- FIN (1 cycle): CS=1, SPC=1, done=1, busy=1. Then IDLE.
- SDI in HOLD, FIN and IDLE holds its last driven value. rdata holds until the next accepted start or reset.
- Latency: done is high exactly 1 + 2*DIV*8*(nbytes+1) + DIV cycles after the start-sampling edge. For DIV=1, nbytes=1 this is 34 cycles.
- Counters:
  - bit counter: 3 bits, wraps 7->0 and advances the byte counter.
  - byte counter: LEN_W+1 bits, counts 0..nbytes. Byte 0 is the command.
  - divider counter: $clog2(DIV+1) bits. DIV=1 must work with no idle gap.
- Inputs addr/read/wdata/len may change freely after the accept edge.
- start held high continuously: a new transaction is accepted on the first IDLE cycle after FIN. There is exactly one idle cycle between transactions.

Test Plan:
- Reset then idle, DIV=1: SPC=1, CS=1, SDI=0, busy=0, rdata=0 for 20 cycles with start=0.
- Write, addr=7'h20, len=1, wdata[7:0]=8'hA5, DIV=1:
  - SDI bits sampled on SPC rising edges = 0,0100000,10100101 (16 bits).
  - CS low for 33 cycles; done pulses 34 cycles after start.
  - rdata stays 0.
- Read, addr=7'h28, len=6, device model returns bytes 01..06, DIV=2:
  - rdata[47:0]=48'h060504030201, upper bytes 0.
  - SPC period = 4 clk; data bits sent on SDI = 0.
  - done at cycle 1 + 4*56 + 2 = 227.
- len=0 and len=15 with MAX_BYTES=12:
  - 16-bit and 104-bit frames respectively (1 and 12 data bytes).
  - SPC rising-edge counts of 16 and 104.
- start pulsed while busy at cycle 10 of a transfer: ignored; exactly one done pulse. Continuous start gives back-to-back frames separated by one CS-high IDLE cycle after FIN.
- reset asserted at cycle 20 of a read: next cycle CS=1, SPC=1, rdata=0, busy=0, no done pulse. A following start completes normally.
